// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the pc_fetch block: reset/limit defaults, FSM state
// encoding and next-PC source encoding.
package pc_fetch_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_3FFC;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/pc_npc.sv
// Combinational next-PC selection: jr > j > br > sequential, 32-bit wrapping.
// PC_BOUND_CHECK_EN keeps jr_target[1:0] so the caller can flag misalignment.
module pc_npc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_en,
  input  logic [15:0] br_imm16,
  input  logic        j_en,
  input  logic [25:0] j_index26,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output npc_sel_e    sel
);

  logic [31:0] br_off;
  logic [31:0] jr_addr;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{br_imm16[15]}}, br_imm16, 2'b00};

`ifdef PC_BOUND_CHECK_EN
  assign jr_addr = jr_target;
`else
  assign jr_addr = jr_target & ~32'd3;
`endif

  always_comb begin
    sel = NPC_SEQ;
    if (jr_en)      sel = NPC_JR;
    else if (j_en)  sel = NPC_J;
    else if (br_en) sel = NPC_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      NPC_JR:  next_pc = jr_addr;
      NPC_J:   next_pc = {pc_plus4[31:28], j_index26, 2'b00};
      NPC_BR:  next_pc = pc_plus4 + br_off;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter register and START/RUN/HALT control FSM feeding instruction memory.
// Optional macro PC_BOUND_CHECK_EN enables alignment/range faulting of next_pc.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        br_en,
  input  logic [15:0] br_imm16,
  input  logic        j_en,
  input  logic [25:0] j_index26,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [9:0]  im_addr,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output pc_state_e   state_dbg
);

  pc_state_e   state, state_nx;
  logic [31:0] pc_nx;
  logic [31:0] next_pc;
  npc_sel_e    npc_sel;
  logic        bad_target;
  logic        fault_nx;

  pc_npc u_npc (
    .pc        (pc),
    .br_en     (br_en),
    .br_imm16  (br_imm16),
    .j_en      (j_en),
    .j_index26 (j_index26),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .sel       (npc_sel)
  );

`ifdef PC_BOUND_CHECK_EN
  logic fault_q;
  assign bad_target = (next_pc[1:0] != 2'b00) || (next_pc < PC_RESET) || (next_pc > PC_LIMIT);
  assign fault      = fault_q;
`else
  assign bad_target = 1'b0;
  assign fault      = 1'b0;
`endif

  assign im_addr   = pc[11:2];
  assign halted    = (state == ST_HALT);
  assign state_dbg = state;

  // Stall outranks redirects and halt_req; a bad target is checked before halt_req.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    fault_nx    = fault;
    fetch_valid = 1'b0;
    case (state)
      ST_START: state_nx = ST_RUN;
      ST_RUN: begin
        fetch_valid = ~stall;
        if (!stall) begin
          if (bad_target) begin
            state_nx = ST_HALT;
            fault_nx = 1'b1;
          end else if (halt_req) begin
            state_nx = ST_HALT;
          end else begin
            pc_nx = next_pc;
          end
        end
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RESET;
      state <= ST_START;
    end else begin
      pc    <= pc_nx;
      state <= state_nx;
    end
  end

`ifdef PC_BOUND_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_nx;
  end
`endif

  // npc_sel is informational only; PC_LIMIT matters only with bound checking.
  logic unused_ok;
  assign unused_ok = ^{npc_sel, PC_LIMIT, fault_nx};

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: reset/start-up, directed redirect table,
// halt and bound-check sequences, then random stimulus against a reference model.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, halt_req, br_en, j_en, jr_en;
  logic [15:0] br_imm16;
  logic [25:0] j_index26;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4;
  logic [9:0]  im_addr;
  logic        fetch_valid, halted, fault;
  pc_state_e   state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
    .br_en(br_en), .br_imm16(br_imm16), .j_en(j_en), .j_index26(j_index26),
    .jr_en(jr_en), .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4),
    .im_addr(im_addr), .fetch_valid(fetch_valid), .halted(halted),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; br_en = 0; j_en = 0; jr_en = 0;
    br_imm16 = '0; j_index26 = '0; jr_target = '0;
  endtask

  // Edge helper: inputs are driven #1 after posedge, so this returns at that point.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic        exp_fv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[$];

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  int          m_phase;   // 0 start-up cycle, 1 running, 2 stopped
  logic        m_fault;

  function automatic logic [31:0] ref_next(input logic [31:0] p);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (jr_en) begin
`ifdef PC_BOUND_CHECK_EN
      return jr_target;
`else
      return (jr_target / 4) * 4;
`endif
    end
    if (j_en) return (p4 & 32'hF000_0000) + {4'd0, j_index26, 2'b00};
    if (br_en) return p4 + 32'(int'($signed(br_imm16)) * 4);
    return p4;
  endfunction

  function automatic bit ref_bad(input logic [31:0] a);
`ifdef PC_BOUND_CHECK_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h3FFC);
`else
    return 0;
`endif
  endfunction

  initial begin
    reset = 1;
    idle();

    // ---- reset and free-running start-up ----
    do_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_fv", {31'd0, fetch_valid}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_START});
    chk("rst_im", {22'd0, im_addr}, 0);
    tick();
    chk("c1_pc", pc, 32'h3000);
    chk("c1_fv", {31'd0, fetch_valid}, 1);
    chk("c1_im", {22'd0, im_addr}, 0);
    tick();
    chk("c2_pc", pc, 32'h3004);
    chk("c2_im", {22'd0, im_addr}, 1);
    chk("c2_p4", pc_plus4, 32'h3008);
    tick();
    chk("c3_pc", pc, 32'h3008);
    chk("c3_im", {22'd0, im_addr}, 2);

    // ---- directed redirect table, starting from pc=0x3008 ----
    vt.push_back('{0, 1, 16'hFFFE, 0, 26'h0,   0, 32'h0,    1, 32'h3004});
    vt.push_back('{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,    1, 32'h3008});
    vt.push_back('{0, 1, 16'h0003, 0, 26'h0,   0, 32'h0,    1, 32'h3018});
    vt.push_back('{0, 0, 16'h0,    1, 26'hC10, 0, 32'h0,    1, 32'h3040});
    vt.push_back('{0, 1, 16'h0010, 1, 26'hC20, 1, 32'h3100, 1, 32'h3100});
    vt.push_back('{1, 1, 16'h0020, 0, 26'h0,   0, 32'h0,    0, 32'h3100});
    vt.push_back('{1, 1, 16'h0020, 0, 26'h0,   0, 32'h0,    0, 32'h3100});
    vt.push_back('{1, 1, 16'h0020, 0, 26'h0,   0, 32'h0,    0, 32'h3100});
    vt.push_back('{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,    1, 32'h3104});
    vt.push_back('{0, 1, 16'h8000, 1, 26'hC08, 0, 32'h0,    1, 32'h3020});
    foreach (vt[i]) begin
      stall = vt[i].stall; br_en = vt[i].br; br_imm16 = vt[i].imm;
      j_en = vt[i].j; j_index26 = vt[i].idx; jr_en = vt[i].jr; jr_target = vt[i].jrt;
      @(negedge clk);
      chk($sformatf("vec%0d_fv", i), {31'd0, fetch_valid}, {31'd0, vt[i].exp_fv});
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vt[i].exp_pc);
    end
    idle();

    // ---- halt at 0x3020, held for 10 cycles, then reset ----
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("halt_halted", {31'd0, halted}, 1);
    br_en = 1; br_imm16 = 16'h0004; jr_en = 1; jr_target = 32'h3200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pc !== 32'h3020 || fetch_valid !== 1'b0 || halted !== 1'b1) begin
        chk("halt_hold_pc", pc, 32'h3020);
        chk("halt_hold_fv", {31'd0, fetch_valid}, 0);
      end else n_cmp++;
      tick();
    end
    chk("halt_final_pc", pc, 32'h3020);
    do_reset();
    chk("halt_rst_pc", pc, 32'h3000);
    chk("halt_rst_halted", {31'd0, halted}, 0);

    // ---- misaligned / out-of-range register jump ----
    tick();
    jr_en = 1; jr_target = 32'h3002;
    tick();
    idle();
`ifdef PC_BOUND_CHECK_EN
    chk("bc_mis_pc", pc, 32'h3000);
    chk("bc_mis_fault", {31'd0, fault}, 1);
    chk("bc_mis_halted", {31'd0, halted}, 1);
`else
    chk("nb_mis_pc", pc, 32'h3000);
    chk("nb_mis_fault", {31'd0, fault}, 0);
    chk("nb_mis_halted", {31'd0, halted}, 0);
`endif
    do_reset();
    tick();
    jr_en = 1; jr_target = 32'h4000;
    tick();
    idle();
`ifdef PC_BOUND_CHECK_EN
    chk("bc_hi_pc", pc, 32'h3000);
    chk("bc_hi_fault", {31'd0, fault}, 1);
    tick(); tick();
    chk("bc_hi_sticky", {31'd0, fault}, 1);
`else
    chk("nb_hi_pc", pc, 32'h4000);
    chk("nb_hi_im", {22'd0, im_addr}, 0);
    chk("nb_hi_fault", {31'd0, fault}, 0);
`endif

    // ---- random stimulus against the reference model ----
    do_reset();
    m_pc = 32'h3000; m_phase = 0; m_fault = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] np;
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      br_en     = ($urandom_range(0, 3) == 0);
      br_imm16  = 16'($signed($urandom_range(0, 80)) - 40);
      j_en      = ($urandom_range(0, 7) == 0);
      j_index26 = 26'($urandom_range(32'hC00, 32'hFFF));
      jr_en     = ($urandom_range(0, 7) == 0);
      jr_target = ($urandom_range(0, 9) == 0) ? $urandom : {20'h3, 10'($urandom), 2'b00};
      halt_req  = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      chk("rnd_pc_pre", pc, m_pc);
      chk("rnd_p4", pc_plus4, m_pc + 32'd4);
      chk("rnd_im", {22'd0, im_addr}, {22'd0, m_pc[11:2]});
      chk("rnd_fv", {31'd0, fetch_valid}, {31'd0, (m_phase == 1) && !stall});
      np = ref_next(m_pc);
      if (reset) begin
        m_pc = 32'h3000; m_phase = 0; m_fault = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1 && !stall) begin
        if (ref_bad(np)) begin m_phase = 2; m_fault = 1; end
        else if (halt_req) m_phase = 2;
        else m_pc = np;
      end
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_halted", {31'd0, halted}, {31'd0, m_phase == 2});
      chk("rnd_fault", {31'd0, fault}, {31'd0, m_fault});
      if (m_phase == 2 && $urandom_range(0, 5) == 0) begin
        do_reset();
        m_pc = 32'h3000; m_phase = 0; m_fault = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
